// File: rtl/qual.sv
// Trigger qualifier: turns the first rising edge on any din bit (while start is high)
// into one four-phase write/write_ack handshake. Define QUAL_INPUT_SYNC_EN to add a
// two-flop synchronizer on din.
module qual #(
  parameter int L = 4
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         start,
  input  logic [L-1:0] din,
  output logic         write,
  input  logic         write_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [L-1:0] din_q;
  logic [L-1:0] din_d;
  logic [L-1:0] rise;
  logic         evt;

`ifdef QUAL_INPUT_SYNC_EN
  logic [L-1:0] sync_p0;
  logic [L-1:0] sync_p1;

  // Synchronizer stages: din may be asynchronous to aclk
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  assign din_q = sync_p1;
`else
  assign din_q = din;
`endif

  // Edge-detector delay stage, free running regardless of start or state
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      din_d <= '0;
    end else begin
      din_d <= din_q;
    end
  end

  assign rise = din_q & ~din_d;
  assign evt  = start & (|rise);

  // Events outside IDLE fall through the default hold and are simply lost
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (evt)        state_nxt = REQ;
      REQ:     if (write_ack)  state_nxt = RELEASE;
      RELEASE: if (!write_ack) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // write is registered from the next state so it changes on the same edge as the FSM
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
      write <= 1'b0;
    end else begin
      state <= state_nxt;
      write <= (state_nxt == REQ);
    end
  end

endmodule

// File: tb/tb_qual.sv
// Directed bench for qual: single-event handshakes, drop rules, held levels and async reset.
module tb_qual;

`ifdef QUAL_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       aclk;
  logic       areset;
  logic       start;
  logic [3:0] din;
  logic       write;
  logic       write_ack;

  int checks = 0;
  int errors = 0;
  int nwr    = 0;
  int base;

  qual #(.L(4)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .start     (start),
    .din       (din),
    .write     (write),
    .write_ack (write_ack)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge write) nwr++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle pattern; write must stay low for LAT-1 cycles and then be high
  task automatic pulse(input logic [3:0] pat);
    din = pat;
    for (int k = 0; k < LAT - 1; k++) begin
      @(negedge aclk);
      din = 4'b0000;
      chk("latency_low", {31'd0, write}, 32'd1 - 32'd1);
    end
    @(negedge aclk);
    din = 4'b0000;
    chk("write_rise", {31'd0, write}, 32'd1);
  endtask

  task automatic handshake();
    write_ack = 1'b1;
    @(negedge aclk);
    chk("write_fall", {31'd0, write}, 32'd0);
    write_ack = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    chk("idle_write", {31'd0, write}, 32'd0);
  endtask

  initial begin
    areset    = 1'b1;
    start     = 1'b0;
    din       = 4'b0000;
    write_ack = 1'b0;
    #12;
    chk("reset_write", {31'd0, write}, 32'd0);
    chk("reset_state", 32'(dut.state), 32'd0);
    chk("reset_din_d", {28'd0, dut.din_d}, 32'd0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);

    // Multi-bit edge counts as one event, repeated 100 times
    start = 1'b1;
    base  = nwr;
    for (int i = 0; i < 100; i++) begin
      chk("pre_write", {31'd0, write}, 32'd0);
      pulse(4'b0011);
      handshake();
    end
    chk("count_100", 32'(nwr - base), 32'd100);

    // Edges with start low are ignored
    start = 1'b0;
    base  = nwr;
    for (int i = 0; i < 10; i++) begin
      din = 4'b0001;
      @(negedge aclk);
      chk("nostart_hi", {31'd0, write}, 32'd0);
      din = 4'b0000;
      @(negedge aclk);
      chk("nostart_lo", {31'd0, write}, 32'd0);
    end
    repeat (LAT + 2) @(negedge aclk);
    start = 1'b1;
    repeat (LAT + 2) @(negedge aclk);
    chk("nostart_count", 32'(nwr - base), 32'd0);

    // Edge during REQ is dropped; start falling mid-handshake does not abort it
    base = nwr;
    pulse(4'b0001);
    din = 4'b0100;
    @(negedge aclk);
    din = 4'b0000;
    start = 1'b0;
    repeat (LAT + 3) @(negedge aclk);
    chk("drop_hold", {31'd0, write}, 32'd1);
    handshake();
    start = 1'b1;
    repeat (LAT + 3) @(negedge aclk);
    chk("drop_after", {31'd0, write}, 32'd0);
    chk("drop_count", 32'(nwr - base), 32'd1);

    // Level held for 50 cycles yields one write; ack simply mirrors write
    base = nwr;
    din  = 4'b1000;
    for (int i = 0; i < 50; i++) begin
      write_ack = write;
      @(negedge aclk);
    end
    write_ack = 1'b0;
    din = 4'b0000;
    repeat (LAT + 3) @(negedge aclk);
    chk("held_count", 32'(nwr - base), 32'd1);
    chk("held_idle", {31'd0, write}, 32'd0);

    // Bit already high when start rises gives no event
    start = 1'b0;
    din   = 4'b0001;
    base  = nwr;
    repeat (LAT + 2) @(negedge aclk);
    start = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge aclk);
      chk("prehigh_write", {31'd0, write}, 32'd0);
    end
    din = 4'b0000;
    repeat (LAT + 2) @(negedge aclk);
    chk("prehigh_count", 32'(nwr - base), 32'd0);

    // Ack already high on entry: exactly one cycle of write
    base = nwr;
    write_ack = 1'b1;
    pulse(4'b0010);
    @(negedge aclk);
    chk("ack_early_fall", {31'd0, write}, 32'd0);
    write_ack = 1'b0;
    repeat (3) @(negedge aclk);
    chk("ack_early_count", 32'(nwr - base), 32'd1);

    // Asynchronous reset while write is high
    pulse(4'b0010);
    #2;
    areset = 1'b1;
    #1;
    chk("async_write", {31'd0, write}, 32'd0);
    chk("async_state", 32'(dut.state), 32'd0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    chk("post_reset_idle", {31'd0, write}, 32'd0);
    base = nwr;
    pulse(4'b0001);
    handshake();
    chk("post_reset_count", 32'(nwr - base), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
